// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: NOP encoding, PC increment, default widths
// and the {pc, instr} entry type carried between fetch and decode.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned PC_INCR    = 4;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetchq_storage.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
// Contents are not reset; occupancy tracking in the parent decides validity.
module fetchq_storage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the presented entry at the write pointer
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling queue: buffers {PC, instruction} pairs from fetch and
// hands them to decode in order over a valid/ready handshake. Flush drops
// everything on redirect. An empty queue presents a NOP bubble at PC 0.
// Optional: define FETCHQ_STATS_EN to add StallCycles / FlushedWords counters.
module if_id_fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Flush,
    input  logic                  InValid,
    input  logic [ADDR_W-1:0]     InPC,
    input  logic [DATA_W-1:0]     InInstr,
    output logic                  InReady,
    output logic                  OutValid,
    output logic [ADDR_W-1:0]     OutPC,
    output logic [ADDR_W-1:0]     OutPCPlus4,
    output logic [DATA_W-1:0]     OutInstr,
    input  logic                  OutReady,
    output logic [$clog2(DEPTH):0] Count
`ifdef FETCHQ_STATS_EN
    ,
    output logic [15:0]           StallCycles,
    output logic [15:0]           FlushedWords
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    assign InReady  = (cnt < CNT_W'(DEPTH));
    assign OutValid = (cnt != '0);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;
    assign Count    = cnt;

    fetchq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_storage (
        .clk   (Clk),
        .we    (push && !Flush),
        .waddr (wptr),
        .wdata ({InPC, InInstr}),
        .raddr (rptr),
        .rdata (head)
    );

    // Head fields; an empty queue shows a NOP at PC 0 so decode sees a bubble
    always_comb begin
        OutPC    = '0;
        OutInstr = DATA_W'(NOP_INSTR);
        if (OutValid) begin
            OutPC    = head[ENT_W-1:DATA_W];
            OutInstr = head[DATA_W-1:0];
        end
    end

    assign OutPCPlus4 = OutPC + ADDR_W'(PC_INCR);

    // Pointer and occupancy update; flush wins over push and pop
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (Flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

`ifdef FETCHQ_STATS_EN
    logic [16:0] stall_sum;
    logic [16:0] flushed_sum;

    // Saturating sums for the statistics counters
    always_comb begin
        stall_sum   = {1'b0, StallCycles} + 17'(1);
        flushed_sum = {1'b0, FlushedWords} + 17'(cnt) + 17'(push);
    end

    // Statistics survive Flush; only Reset clears them
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            StallCycles  <= '0;
            FlushedWords <= '0;
        end else begin
            if (InValid && !InReady) begin
                StallCycles <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
            end
            if (Flush) begin
                FlushedWords <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
            end
        end
    end
`endif

endmodule
